l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Shares the single L2 cache port between the L1 I-cache miss path and the L1 D-cache miss/write-back path.
//  Sits between both L1 controllers and the L2 cache, and sequences one L2 transaction at a time.
//  Ties are resolved round-robin; requester address/data are latched at grant.
//  Completion is returned to the owning requester as a one-cycle ready pulse.
// PARAMETERS
//  ADDR_W  28   block address width (word address [29:2] minus offset)
//  LINE_W  128  cache line width in bits (4 words)
// PORTS
//  clk              in   1       system clock, all logic on rising edge
//  rst              in   1       synchronous reset, active-high
//  icache_read_i    in   1       I-side line fill request, held until icache_ready_o
//  icache_addr_i    in   ADDR_W  I-side block address
//  icache_rdata_o   out  LINE_W  fill data, valid while icache_ready_o=1
//  icache_ready_o   out  1       one-cycle completion pulse to I-side
//  dcache_read_i    in   1       D-side line fill request, held until dcache_ready_o
//  dcache_write_i   in   1       D-side write-back request, held until dcache_ready_o
//  dcache_addr_i    in   ADDR_W  D-side block address
//  dcache_wdata_i   in   LINE_W  D-side write-back line
//  dcache_rdata_o   out  LINE_W  fill data, valid while dcache_ready_o=1
//  dcache_ready_o   out  1       one-cycle completion pulse to D-side
//  l2_read_o        out  1       L2 read strobe, held until l2_ready_i
//  l2_write_o       out  1       L2 write strobe, held until l2_ready_i
//  l2_addr_o        out  ADDR_W  latched address of granted requester
//  l2_wdata_o       out  LINE_W  latched write-back line
//  l2_rdata_i       in   LINE_W  L2 read data, valid with l2_ready_i
//  l2_ready_i       in   1       L2 completion, one-cycle pulse
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, prio_d=1 (D wins first tie).
//  - FSM states: IDLE, SERVE_I, SERVE_D, RELEASE.
//  - IDLE: if only one side requests, grant that side. If both request, grant per prio_d.
//    On grant: latch addr/wdata/op, go to SERVE_x, and set l2_read_o/l2_write_o at the next edge.
//  - Request-to-L2 latency: 1 cycle. Request seen at edge t means the L2 strobe is high after t.
//  - SERVE_x: hold strobe/addr/wdata stable and ignore requester input changes.
//    On l2_ready_i: drop strobes, register l2_rdata_i into x_rdata_o, pulse x_ready_o for 1 cycle,
//    flip prio_d to favour the other side, then go to RELEASE.
//  - RELEASE: 1 cycle with no grants, so the requester can deassert after seeing ready. Then IDLE.
//  - Minimum back-to-back spacing: 1 cycle grant + L2 latency + ready + RELEASE.
//  - dcache_read_i and dcache_write_i both high is illegal. The write wins and an assertion fires.
//  - l2_ready_i in IDLE or RELEASE is ignored and triggers an assertion.
//  - rdata outputs hold their last value when ready=0; consumers sample only with ready.
//  - Reset mid-transaction: immediately return to IDLE, strobes drop, no ready pulse is issued.
//    The L2 is reset by the same rst.
//  - No timeout: a hung L2 stalls both sides indefinitely (matches core stall semantics).
// STRUCTURE
//  - Shared include l2_defs.vh: ADDR_W/LINE_W defaults and FSM state localparams (2-bit).
//  - Sub-module rr_arb2: 2-way round-robin picker.
//    Inputs req[1:0] and prio; outputs a one-hot gnt[1:0]; purely combinational.
//  - Top level: FSM, latch registers, output registers.
// TESTING
//  - Solo I: icache_read_i=1, addr=0x0000010, L2 ready 4 cycles later with 0xA5..A5.
//    -> l2_read_o high 1 cycle after the request; icache_ready_o pulses once with data A5..A5.
//  - Tie after reset: both read at the same edge -> D granted first (l2_addr_o=D addr).
//    After RELEASE, I is granted. dcache_ready_o precedes icache_ready_o.
//  - Fairness: D holds requests continuously while I requests once.
//    -> I is granted on the very next IDLE; D is not served twice in a row.
//  - Write-back: dcache_write_i=1, wdata=0xDEADBEEF_x4.
//    -> l2_write_o=1 with l2_wdata_o matching, l2_read_o=0, dcache_ready_o pulse, icache_ready_o stays 0.
//  - Input change during SERVE: I addr changes mid-transaction -> l2_addr_o keeps the latched value.
//  - Reset mid-op: rst in SERVE_D -> next edge all outputs 0, state IDLE, no ready pulse.
//    Subsequent requests are served normally.

Source files
------------

// File: rtl/l2_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the L2 port arbiter.
package l2_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/l2_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit0 = I-side, bit1 = D-side; i_prio=1 favours D on a tie.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = i_prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between the L1 I-cache fill path and the L1 D-cache fill/write-back path.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic [LINE_W-1:0] icache_rdata_o,
  output logic              icache_ready_o,
  input  logic              dcache_read_i,
  input  logic              dcache_write_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  output logic [LINE_W-1:0] dcache_rdata_o,
  output logic              dcache_ready_o,
  output logic              l2_read_o,
  output logic              l2_write_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [LINE_W-1:0] l2_wdata_o,
  input  logic [LINE_W-1:0] l2_rdata_i,
  input  logic              l2_ready_i
);

  arb_state_e r_state, w_state_nxt;
  logic       r_prio_d;
  logic [1:0] w_req, w_gnt;

  assign w_req = {dcache_read_i | dcache_write_i, icache_read_i};

  rr_arb2 u_rr (
    .i_req  (w_req),
    .i_prio (r_prio_d),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt[1])      w_state_nxt = SERVE_D;
        else if (w_gnt[0]) w_state_nxt = SERVE_I;
      end
      SERVE_I, SERVE_D: if (l2_ready_i) w_state_nxt = RELEASE;
      RELEASE:          w_state_nxt = IDLE;
      default:          w_state_nxt = IDLE;
    endcase
  end

  // Grant latches the request; the L2 strobe rises on the same edge the state leaves IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_d       <= 1'b1;
      icache_rdata_o <= '0;
      icache_ready_o <= 1'b0;
      dcache_rdata_o <= '0;
      dcache_ready_o <= 1'b0;
      l2_read_o      <= 1'b0;
      l2_write_o     <= 1'b0;
      l2_addr_o      <= '0;
      l2_wdata_o     <= '0;
    end else begin
      icache_ready_o <= 1'b0;
      dcache_ready_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt[1]) begin
            // A simultaneous read+write from D is treated as the write.
            l2_addr_o  <= dcache_addr_i;
            l2_write_o <= dcache_write_i;
            l2_read_o  <= ~dcache_write_i;
            l2_wdata_o <= dcache_wdata_i;
          end else if (w_gnt[0]) begin
            l2_addr_o  <= icache_addr_i;
            l2_read_o  <= 1'b1;
            l2_write_o <= 1'b0;
            l2_wdata_o <= '0;
          end
        end
        SERVE_I: begin
          if (l2_ready_i) begin
            l2_read_o      <= 1'b0;
            l2_write_o     <= 1'b0;
            icache_rdata_o <= l2_rdata_i;
            icache_ready_o <= 1'b1;
            r_prio_d       <= 1'b1;
          end
        end
        SERVE_D: begin
          if (l2_ready_i) begin
            l2_read_o      <= 1'b0;
            l2_write_o     <= 1'b0;
            dcache_rdata_o <= l2_rdata_i;
            dcache_ready_o <= 1'b1;
            r_prio_d       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !(dcache_read_i && dcache_write_i));

  a_ready_in_serve: assert property (@(posedge clk) disable iff (rst)
    l2_ready_i |-> (r_state == SERVE_I || r_state == SERVE_D));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: L2 responder model, grant/ready scoreboard, scenario tasks.
module tb_l2_port_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_read_i = 1'b0;
  logic [AW-1:0] icache_addr_i = '0;
  logic [LW-1:0] icache_rdata_o;
  logic          icache_ready_o;
  logic          dcache_read_i = 1'b0;
  logic          dcache_write_i = 1'b0;
  logic [AW-1:0] dcache_addr_i = '0;
  logic [LW-1:0] dcache_wdata_i = '0;
  logic [LW-1:0] dcache_rdata_o;
  logic          dcache_ready_o;
  logic          l2_read_o;
  logic          l2_write_o;
  logic [AW-1:0] l2_addr_o;
  logic [LW-1:0] l2_wdata_o;
  logic [LW-1:0] l2_rdata_i;
  logic          l2_ready_i;

  always #5 clk = ~clk;

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read_i  (icache_read_i),
    .icache_addr_i  (icache_addr_i),
    .icache_rdata_o (icache_rdata_o),
    .icache_ready_o (icache_ready_o),
    .dcache_read_i  (dcache_read_i),
    .dcache_write_i (dcache_write_i),
    .dcache_addr_i  (dcache_addr_i),
    .dcache_wdata_i (dcache_wdata_i),
    .dcache_rdata_o (dcache_rdata_o),
    .dcache_ready_o (dcache_ready_o),
    .l2_read_o      (l2_read_o),
    .l2_write_o     (l2_write_o),
    .l2_addr_o      (l2_addr_o),
    .l2_wdata_o     (l2_wdata_o),
    .l2_rdata_i     (l2_rdata_i),
    .l2_ready_i     (l2_ready_i)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
  } txn_t;

  int            errors = 0;
  int            checks = 0;
  int            l2_lat = 4;
  txn_t          exp_l2[$];
  logic [LW-1:0] exp_i[$];
  logic [LW-1:0] exp_d[$];
  logic [LW-1:0] l2_mem [logic [AW-1:0]];
  time           t_i_done, t_d_done;

  function automatic logic [LW-1:0] mem_of(input logic [AW-1:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return {4{4'h0, a}};
  endfunction

  function automatic txn_t mk(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd);
    txn_t t;
    t.addr = a; t.wr = w; t.wdata = wd;
    return t;
  endfunction

  // L2 model: answers l2_lat cycles after it first sees a strobe, with a one-cycle ready.
  initial begin
    int cnt;
    cnt = 0;
    l2_ready_i = 1'b0;
    l2_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (l2_ready_i) begin
        l2_ready_i = 1'b0;
        cnt = 0;
      end else if (!rst && (l2_read_o || l2_write_o)) begin
        cnt++;
        if (cnt >= l2_lat) begin
          l2_ready_i = 1'b1;
          l2_rdata_i = mem_of(l2_addr_o);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: grants are compared on the strobe's rising cycle, ready data on each pulse.
  initial begin
    txn_t cur;
    logic prev_stb, prev_ir, prev_dr;
    logic [LW-1:0] e;
    cur = mk('0, 1'b0, '0);
    prev_stb = 0; prev_ir = 0; prev_dr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stb = 0; prev_ir = 0; prev_dr = 0;
      end else begin
        if ((l2_read_o || l2_write_o) && !prev_stb) begin
          checks++;
          if (exp_l2.size() == 0) begin
            errors++;
            $display("FAIL l2_unexpected_grant addr=%h rd=%b wr=%b", l2_addr_o, l2_read_o, l2_write_o);
          end else begin
            cur = exp_l2.pop_front();
            if (l2_addr_o !== cur.addr || l2_write_o !== cur.wr || l2_read_o !== !cur.wr ||
                (cur.wr && l2_wdata_o !== cur.wdata)) begin
              errors++;
              $display("FAIL l2_grant got addr=%h rd=%b wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                       l2_addr_o, l2_read_o, l2_write_o, l2_wdata_o, cur.addr, cur.wr, cur.wdata);
            end
          end
        end else if (l2_read_o || l2_write_o) begin
          checks++;
          if (l2_addr_o !== cur.addr || (cur.wr && l2_wdata_o !== cur.wdata)) begin
            errors++;
            $display("FAIL l2_hold got addr=%h want addr=%h", l2_addr_o, cur.addr);
          end
        end
        if (icache_ready_o) begin
          checks++;
          if (prev_ir) begin
            errors++; $display("FAIL i_ready_width got 2+ cycles want 1");
          end else if (exp_i.size() == 0) begin
            errors++; $display("FAIL i_ready_unexpected data=%h", icache_rdata_o);
          end else begin
            e = exp_i.pop_front();
            if (icache_rdata_o !== e) begin
              errors++; $display("FAIL i_rdata got %h want %h", icache_rdata_o, e);
            end
          end
        end
        if (dcache_ready_o) begin
          checks++;
          if (prev_dr) begin
            errors++; $display("FAIL d_ready_width got 2+ cycles want 1");
          end else if (exp_d.size() == 0) begin
            errors++; $display("FAIL d_ready_unexpected data=%h", dcache_rdata_o);
          end else begin
            e = exp_d.pop_front();
            if (dcache_rdata_o !== e) begin
              errors++; $display("FAIL d_rdata got %h want %h", dcache_rdata_o, e);
            end
          end
        end
        prev_stb = l2_read_o || l2_write_o;
        prev_ir  = icache_ready_o;
        prev_dr  = dcache_ready_o;
      end
    end
  end

  task automatic req_i(input logic [AW-1:0] a);
    int n;
    icache_addr_i = a;
    icache_read_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!icache_ready_o && n < 60);
    if (!icache_ready_o) begin
      checks++; errors++;
      $display("FAIL i_timeout addr=%h got no ready want ready", a);
    end
    t_i_done = $time;
    icache_read_i = 1'b0;
  endtask

  task automatic req_d(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd, input logic keep);
    int n;
    dcache_addr_i  = a;
    dcache_wdata_i = wd;
    dcache_write_i = w;
    dcache_read_i  = !w;
    n = 0;
    do begin @(negedge clk); n++; end while (!dcache_ready_o && n < 60);
    if (!dcache_ready_o) begin
      checks++; errors++;
      $display("FAIL d_timeout addr=%h got no ready want ready", a);
    end
    t_d_done = $time;
    if (!keep) begin
      dcache_read_i  = 1'b0;
      dcache_write_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({l2_read_o, l2_write_o, icache_ready_o, dcache_ready_o} !== 4'b0 ||
        l2_addr_o !== '0 || l2_wdata_o !== '0 || icache_rdata_o !== '0 || dcache_rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%b ir=%b dr=%b addr=%h want all 0",
               l2_read_o, l2_write_o, icache_ready_o, dcache_ready_o, l2_addr_o);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_solo_i();
    int n;
    l2_mem[28'h10] = {16{8'hA5}};
    exp_l2.push_back(mk(28'h10, 1'b0, '0));
    exp_i.push_back({16{8'hA5}});
    icache_addr_i = 28'h10;
    icache_read_i = 1'b1;
    @(negedge clk);
    checks++;
    if (l2_read_o !== 1'b1 || l2_write_o !== 1'b0 || l2_addr_o !== 28'h10) begin
      errors++;
      $display("FAIL solo_i_latency got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=0000010",
               l2_read_o, l2_write_o, l2_addr_o);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!icache_ready_o && n < 60);
    checks++;
    if (n != l2_lat || icache_rdata_o !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL solo_i_ready got cycles=%0d data=%h want cycles=%0d data=a5..a5", n, icache_rdata_o, l2_lat);
    end
    icache_read_i = 1'b0;
    @(negedge clk);
    checks++;
    if (icache_ready_o !== 1'b0 || l2_read_o !== 1'b0) begin
      errors++;
      $display("FAIL solo_i_after got ready=%b rd=%b want 0 0", icache_ready_o, l2_read_o);
    end
    idle(2);
  endtask

  task automatic test_tie();
    exp_l2.push_back(mk(28'h200, 1'b0, '0));
    exp_l2.push_back(mk(28'h100, 1'b0, '0));
    exp_d.push_back(mem_of(28'h200));
    exp_i.push_back(mem_of(28'h100));
    fork
      req_d(28'h200, 1'b0, '0, 1'b0);
      req_i(28'h100);
    join
    checks++;
    if (!(t_d_done < t_i_done)) begin
      errors++;
      $display("FAIL tie_order got d_done=%0t i_done=%0t want d before i", t_d_done, t_i_done);
    end
    idle(2);
  endtask

  task automatic test_fairness();
    exp_l2.push_back(mk(28'h300, 1'b0, '0));
    exp_l2.push_back(mk(28'h110, 1'b0, '0));
    exp_l2.push_back(mk(28'h301, 1'b0, '0));
    exp_d.push_back(mem_of(28'h300));
    exp_i.push_back(mem_of(28'h110));
    exp_d.push_back(mem_of(28'h301));
    fork
      begin
        req_d(28'h300, 1'b0, '0, 1'b1);
        req_d(28'h301, 1'b0, '0, 1'b0);
      end
      begin
        idle(2);
        req_i(28'h110);
      end
    join
    checks++;
    if (!(t_i_done < t_d_done)) begin
      errors++;
      $display("FAIL fairness_order got i_done=%0t d_done=%0t want i before second d", t_i_done, t_d_done);
    end
    idle(2);
  endtask

  task automatic test_writeback();
    int n;
    logic saw_wr, saw_rd, saw_ir;
    logic [LW-1:0] wd;
    wd = {4{32'hDEADBEEF}};
    exp_l2.push_back(mk(28'h400, 1'b1, wd));
    exp_d.push_back(mem_of(28'h400));
    dcache_addr_i  = 28'h400;
    dcache_wdata_i = wd;
    dcache_write_i = 1'b1;
    n = 0; saw_wr = 0; saw_rd = 0; saw_ir = 0;
    do begin
      @(negedge clk); n++;
      saw_wr |= l2_write_o; saw_rd |= l2_read_o; saw_ir |= icache_ready_o;
      if (l2_write_o && l2_wdata_o !== wd) begin
        checks++; errors++;
        $display("FAIL wb_wdata got %h want %h", l2_wdata_o, wd);
      end
    end while (!dcache_ready_o && n < 60);
    dcache_write_i = 1'b0;
    checks++;
    if (saw_wr !== 1'b1 || saw_rd !== 1'b0 || saw_ir !== 1'b0 || dcache_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wb_strobes got wr=%b rd=%b i_ready=%b d_ready=%b want 1 0 0 1",
               saw_wr, saw_rd, saw_ir, dcache_ready_o);
    end
    idle(2);
  endtask

  task automatic test_input_change();
    exp_l2.push_back(mk(28'h120, 1'b0, '0));
    exp_i.push_back(mem_of(28'h120));
    fork
      req_i(28'h120);
      begin
        idle(2);
        icache_addr_i = 28'h7FF;
        @(negedge clk);
        checks++;
        if (l2_addr_o !== 28'h120) begin
          errors++;
          $display("FAIL input_change_addr got %h want 0000120", l2_addr_o);
        end
      end
    join
    idle(2);
  endtask

  task automatic test_reset_midop();
    exp_l2.push_back(mk(28'h500, 1'b0, '0));
    dcache_addr_i = 28'h500;
    dcache_read_i = 1'b1;
    @(negedge clk);
    checks++;
    if (l2_read_o !== 1'b1) begin
      errors++; $display("FAIL midop_grant got rd=%b want 1", l2_read_o);
    end
    rst = 1'b1;
    dcache_read_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({l2_read_o, l2_write_o, icache_ready_o, dcache_ready_o} !== 4'b0 || l2_addr_o !== '0) begin
      errors++;
      $display("FAIL midop_reset got rd=%b wr=%b ir=%b dr=%b addr=%h want all 0",
               l2_read_o, l2_write_o, icache_ready_o, dcache_ready_o, l2_addr_o);
    end
    rst = 1'b0;
    idle(6);
    exp_l2.push_back(mk(28'h510, 1'b0, '0));
    exp_d.push_back(mem_of(28'h510));
    req_d(28'h510, 1'b0, '0, 1'b0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_solo_i();
    test_tie();
    test_fairness();
    test_writeback();
    test_input_change();
    test_reset_midop();
    checks++;
    if (exp_l2.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL drain got l2=%0d i=%0d d=%0d pending want 0", exp_l2.size(), exp_i.size(), exp_d.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
